la_capture: RTL and testbench

16-bit logic-analyzer capture engine running in the 148.5 MHz PLL output domain (27 MHz × 11 / 2). It synchronizes the probe pins, decimates them with a programmable sample divider, and evaluates a mask/value trigger. It writes a circular window of 2^ADDR_W samples into the downstream sample RAM, placed around the trigger point. Readout logic takes over once `done` is set.

---
 rtl/la_pkg.sv | 21 ++
 rtl/la_trigger_match.sv | 65 ++++++
 rtl/la_capture.sv | 227 ++++++++++++++++++++++
 tb/tb_la_capture.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/la_pkg.sv
// Shared definitions for the la_capture logic-analyzer block.
// Contents:
//   la_state_e  - capture FSM states
//   LA_DATA_W   - default probe/sample width
//   LA_ADDR_W   - default sample RAM address width
//   LA_DIV_W    - default sample divider width
package la_pkg;

    localparam int unsigned LA_DATA_W = 16;
    localparam int unsigned LA_ADDR_W = 12;
    localparam int unsigned LA_DIV_W  = 16;

    typedef enum logic [2:0] {
        StIdle,
        StPre,
        StWait,
        StPost,
        StDone
    } la_state_e;

endpackage

// File: rtl/la_trigger_match.sv
// Trigger comparator for la_capture.
// Level match: every masked bit of the sample equals trig_value.
// With LA_EDGE_TRIG_EN defined, masked bits that are also set in trig_edge
// additionally require that the previous WAIT-strobe sample differed from
// trig_value; the history is invalid on the first WAIT strobe.
// Ports:
//   clk, rst    - clock / async active-high reset (edge build only)
//   in_wait     - capture is in WAIT this cycle (edge build only)
//   eval        - a WAIT strobe is consuming the sample (edge build only)
//   trig_edge   - per-bit edge qualifier (edge build only)
//   sample      - synchronized probe value
//   trig_mask   - 1 = bit participates
//   trig_value  - required level per masked bit
//   match       - combinational match result
module la_trigger_match
    import la_pkg::*;
#(
    parameter int unsigned DATA_W = LA_DATA_W
) (
`ifdef LA_EDGE_TRIG_EN
    input  logic              clk,
    input  logic              rst,
    input  logic              in_wait,
    input  logic              eval,
    input  logic [DATA_W-1:0] trig_edge,
`endif
    input  logic [DATA_W-1:0] sample,
    input  logic [DATA_W-1:0] trig_mask,
    input  logic [DATA_W-1:0] trig_value,
    output logic              match
);

    logic level_ok;

    assign level_ok = ((sample ^ trig_value) & trig_mask) == '0;

`ifdef LA_EDGE_TRIG_EN
    logic [DATA_W-1:0] prev_q;
    logic              prev_valid_q;
    logic [DATA_W-1:0] edge_bits;
    logic              edge_ok;

    // History only lives while in WAIT, so every new WAIT phase starts invalid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
        end else if (!in_wait) begin
            prev_valid_q <= 1'b0;
        end else if (eval) begin
            prev_q       <= sample;
            prev_valid_q <= 1'b1;
        end
    end

    assign edge_bits = trig_mask & trig_edge;
    // Each edge bit needs prev != value; without valid history no edge bit can match.
    assign edge_ok   = ((edge_bits & ~(prev_q ^ trig_value)) == '0) &&
                       (prev_valid_q || (edge_bits == '0));
    assign match     = level_ok && edge_ok;
`else
    assign match = level_ok;
`endif

endmodule

// File: rtl/la_capture.sv
// la_capture: 16-bit logic-analyzer capture engine.
// Synchronizes the probe pins, decimates them with a programmable divider and
// writes a circular window of 2^ADDR_W samples around a mask/value trigger.
// Optional feature macro: LA_EDGE_TRIG_EN (adds trig_edge, edge-qualified bits).
// Ports:
//   clk, rst         - clock, asynchronous active-high reset
//   probe_i          - asynchronous probe pins
//   arm, abort       - single-cycle start / cancel requests (abort wins)
//   div              - sample every div+1 clocks
//   trig_mask/value  - trigger mask and required levels
//   pre_count        - samples kept before the trigger sample
//   trig_edge        - edge qualifier per bit (LA_EDGE_TRIG_EN only)
//   mem_we/addr/data - sample RAM write port
//   trig_addr        - RAM address of the trigger sample
//   busy             - capture running (PRE, WAIT, POST)
//   triggered        - trigger fired in the current capture
//   done             - capture complete
module la_capture
    import la_pkg::*;
#(
    parameter int unsigned DATA_W = LA_DATA_W,
    parameter int unsigned ADDR_W = LA_ADDR_W,
    parameter int unsigned DIV_W  = LA_DIV_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] probe_i,
    input  logic              arm,
    input  logic              abort,
    input  logic [DIV_W-1:0]  div,
    input  logic [DATA_W-1:0] trig_mask,
    input  logic [DATA_W-1:0] trig_value,
    input  logic [ADDR_W-1:0] pre_count,
`ifdef LA_EDGE_TRIG_EN
    input  logic [DATA_W-1:0] trig_edge,
`endif
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic [ADDR_W-1:0] trig_addr,
    output logic              busy,
    output logic              triggered,
    output logic              done
);

    logic [DATA_W-1:0] sync1_q, sync2_q;
    la_state_e         state_q, state_d, eff_state;

    logic [DIV_W-1:0]  div_q, cfg_div;
    logic [DATA_W-1:0] mask_q, value_q, cfg_mask, cfg_value;
    logic [ADDR_W-1:0] pre_q, cfg_pre;

    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d, eff_addr;
    logic [ADDR_W-1:0] phase_q, phase_d, eff_phase, phase_inc, post_len;

    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;
    logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
    logic              triggered_q, triggered_d;
    logic              done_q, done_d;

    logic              arm_ok, active, strobe, match;

    // The arm cycle itself is processed as if already in PRE/WAIT with the
    // incoming configuration, so with div=0 the first write lands at arm+1.
    assign arm_ok    = arm && !abort && (state_q == StIdle || state_q == StDone);
    assign cfg_div   = arm_ok ? div        : div_q;
    assign cfg_mask  = arm_ok ? trig_mask  : mask_q;
    assign cfg_value = arm_ok ? trig_value : value_q;
    assign cfg_pre   = arm_ok ? pre_count  : pre_q;
    assign eff_state = arm_ok ? ((pre_count == '0) ? StWait : StPre) : state_q;
    assign eff_addr  = arm_ok ? '0 : addr_q;
    assign eff_phase = arm_ok ? '0 : phase_q;
    assign phase_inc = eff_phase + ADDR_W'(1);
    assign post_len  = ~cfg_pre;  // 2^ADDR_W - 1 - pre_count

    assign active = !abort &&
                    (eff_state == StPre || eff_state == StWait || eff_state == StPost);
    // Counter sits at 0 outside a capture, so the arm cycle is always a strobe.
    assign strobe = active && (cnt_q == '0);

`ifdef LA_EDGE_TRIG_EN
    logic [DATA_W-1:0] edge_q, cfg_edge;
    logic              in_wait, wait_strobe;

    assign cfg_edge    = arm_ok ? trig_edge : edge_q;
    assign in_wait     = active && (eff_state == StWait);
    assign wait_strobe = strobe && (eff_state == StWait);
`endif

    la_trigger_match #(
        .DATA_W(DATA_W)
    ) u_match (
`ifdef LA_EDGE_TRIG_EN
        .clk       (clk),
        .rst       (rst),
        .in_wait   (in_wait),
        .eval      (wait_strobe),
        .trig_edge (cfg_edge),
`endif
        .sample    (sync2_q),
        .trig_mask (cfg_mask),
        .trig_value(cfg_value),
        .match     (match)
    );

    always_comb begin
        state_d     = eff_state;
        cnt_d       = cnt_q;
        addr_d      = eff_addr;
        phase_d     = eff_phase;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        trig_addr_d = trig_addr_q;
        triggered_d = arm_ok ? 1'b0 : triggered_q;
        done_d      = (state_q == StDone) && !arm_ok;

        if (abort) begin
            state_d     = StIdle;
            cnt_d       = '0;
            addr_d      = addr_q;
            phase_d     = '0;
            triggered_d = 1'b0;
            done_d      = 1'b0;
        end else if (active) begin
            cnt_d = (cnt_q == '0) ? cfg_div : cnt_q - DIV_W'(1);
            if (strobe) begin
                mem_we_d   = 1'b1;
                mem_addr_d = eff_addr;
                mem_data_d = sync2_q;
                addr_d     = eff_addr + ADDR_W'(1);
                unique case (eff_state)
                    StPre: begin
                        if (phase_inc == cfg_pre) begin
                            state_d = StWait;
                            phase_d = '0;
                        end else begin
                            phase_d = phase_inc;
                        end
                    end
                    StWait: begin
                        if (match) begin
                            trig_addr_d = eff_addr;
                            triggered_d = 1'b1;
                            phase_d     = '0;
                            state_d     = (post_len == '0) ? StDone : StPost;
                        end
                    end
                    StPost: begin
                        if (phase_inc == post_len) begin
                            state_d = StDone;
                        end else begin
                            phase_d = phase_inc;
                        end
                    end
                    default: ;
                endcase
            end
            // Park the divider at 0 so the next arm strobes immediately.
            if (state_d == StDone) begin
                cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            state_q     <= StIdle;
            cnt_q       <= '0;
            addr_q      <= '0;
            phase_q     <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            trig_addr_q <= '0;
            triggered_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            sync1_q     <= probe_i;
            sync2_q     <= sync1_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            phase_q     <= phase_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            trig_addr_q <= trig_addr_d;
            triggered_q <= triggered_d;
            done_q      <= done_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q   <= '0;
            mask_q  <= '0;
            value_q <= '0;
            pre_q   <= '0;
`ifdef LA_EDGE_TRIG_EN
            edge_q  <= '0;
`endif
        end else if (arm_ok) begin
            div_q   <= div;
            mask_q  <= trig_mask;
            value_q <= trig_value;
            pre_q   <= pre_count;
`ifdef LA_EDGE_TRIG_EN
            edge_q  <= trig_edge;
`endif
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_data  = mem_data_q;
    assign trig_addr = trig_addr_q;
    assign triggered = triggered_q;
    assign done      = done_q;
    assign busy      = (state_q == StPre) || (state_q == StWait) || (state_q == StPost);

endmodule

// File: tb/tb_la_capture.sv
// Scoreboard bench for la_capture. The probe pins follow a per-cycle pattern
// table; for each capture the expected write stream is derived from that table
// (strobe k at arm + k*(div+1), sample = probe two clocks earlier, address
// k mod 4096, pre / wait-until-match / post phases) and queued. A monitor pops
// and compares on every mem_we.
module tb_la_capture;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DIV_W  = 16;
    localparam int unsigned DEPTH  = 4096;
    localparam int unsigned PAT_N  = 1 << 17;

    typedef struct packed {
        logic [31:0]       cyc;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] probe_i;
    logic              arm, abort;
    logic [DIV_W-1:0]  div;
    logic [DATA_W-1:0] trig_mask, trig_value, trig_edge;
    logic [ADDR_W-1:0] pre_count;
    logic              mem_we, busy, triggered, done;
    logic [ADDR_W-1:0] mem_addr, trig_addr;
    logic [DATA_W-1:0] mem_data;

    int unsigned cyc = 0;
    int unsigned n_tests = 0;
    int unsigned n_fail = 0;
    int unsigned n_writes = 0;
    logic [DATA_W-1:0] pat [PAT_N];
    wr_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    la_capture #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .DIV_W (DIV_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .probe_i   (probe_i),
        .arm       (arm),
        .abort     (abort),
        .div       (div),
        .trig_mask (trig_mask),
        .trig_value(trig_value),
        .pre_count (pre_count),
`ifdef LA_EDGE_TRIG_EN
        .trig_edge (trig_edge),
`endif
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .trig_addr (trig_addr),
        .busy      (busy),
        .triggered (triggered),
        .done      (done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Probe driver: interval k carries pat[k].
    initial begin
        probe_i = '0;
        forever begin
            @(posedge clk);
            #1;
            probe_i = pat[cyc];
        end
    end

    // Monitor: every write must be the next expected one, in the expected cycle.
    always @(negedge clk) begin
        if (!rst && mem_we) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL spurious_write: addr 0x%0h data 0x%0h at cycle %0d, none expected",
                         mem_addr, mem_data, cyc);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_cycle", cyc, e.cyc);
                check("wr_addr", 32'(mem_addr), 32'(e.addr));
                check("wr_data", 32'(mem_data), 32'(e.data));
            end
            n_writes++;
        end
    end

    // shape: 0 keep random, 1 counter, 2 hold trigger bit15 off for 10000 strobes,
    // 3 bit0 high for 50 strobes, low for 3, then high.
    task automatic run_capture(input string name, input int unsigned dv,
                               input logic [DATA_W-1:0] msk, input logic [DATA_W-1:0] val,
                               input logic [DATA_W-1:0] edg, input int unsigned pre,
                               input int shape, input int unsigned abort_off);
        int unsigned a, s, t, total, exp_trig_cyc, exp_done_cyc, exp_nwr, bound;
        int unsigned trig_cyc, done_cyc, wr_start;
        logic [DATA_W-1:0] x, xprev, eb;
        bit found;

        @(posedge clk);
        #1;
        a = cyc + 4;
        for (int i = 0; i < 14500; i++) begin
            if (shape == 1) pat[a - 2 + i] = DATA_W'(i + 1);
            if (shape == 2) pat[a - 2 + i][15] = (i == 10000);
            if (shape == 3) pat[a - 2 + i][0] = !(i >= 50 && i < 53);
        end

        // Reference model: find the first matching WAIT strobe.
        found = 1'b0;
        t     = 0;
        eb    = msk & edg;
        xprev = '0;
        for (int unsigned j = pre; j < pre + 20000; j++) begin
            x = pat[a - 2 + j * (dv + 1)];
            if ((((x ^ val) & msk) == '0) &&
                ((eb == '0) || (j > pre && ((xprev ^ val) & eb) == eb))) begin
                found = 1'b1;
                t     = j;
                break;
            end
            xprev = x;
        end
        if (!found) begin
            $display("FAIL %s_model: no trigger in stimulus, got none, expected one", name);
            $fatal(1);
        end
        total   = t + DEPTH - pre;
        exp_nwr = 0;
        for (int unsigned j = 0; j < total; j++) begin
            s = a + j * (dv + 1);
            if (abort_off == 0 || s < a + abort_off) begin
                exp_q.push_back('{cyc: s + 1, addr: ADDR_W'(j % DEPTH), data: pat[s - 2]});
                exp_nwr++;
            end
        end
        exp_trig_cyc = a + t * (dv + 1) + 1;
        exp_done_cyc = a + (total - 1) * (dv + 1) + 2;
        bound        = (abort_off != 0) ? a + abort_off + 10 : exp_done_cyc + 20;

        repeat (4) @(posedge clk);
        #1;
        arm        = 1'b1;
        div        = DIV_W'(dv);
        trig_mask  = msk;
        trig_value = val;
        trig_edge  = edg;
        pre_count  = ADDR_W'(pre);
        wr_start   = n_writes;
        trig_cyc   = 0;
        done_cyc   = 0;

        while (cyc < bound && done_cyc == 0) begin
            @(posedge clk);
            #1;
            arm   = (cyc == a + 7);  // ignored while busy
            abort = (abort_off != 0 && cyc == a + abort_off);
            if (cyc == a + 1 || arm) begin
                div        = DIV_W'($urandom);
                trig_mask  = DATA_W'($urandom);
                trig_value = DATA_W'($urandom);
                trig_edge  = DATA_W'($urandom);
                pre_count  = ADDR_W'($urandom);
            end
            @(negedge clk);
            if (triggered && trig_cyc == 0) trig_cyc = cyc;
            if (done && done_cyc == 0) done_cyc = cyc;
            if (cyc == a + 1) check({name, "_busy"}, 32'(busy), 32'd1);
            if (abort_off != 0 && cyc == a + abort_off + 1) begin
                check({name, "_abort_busy"}, 32'(busy), 32'd0);
                check({name, "_abort_done"}, 32'(done), 32'd0);
                check({name, "_abort_trig"}, 32'(triggered), 32'd0);
            end
        end
        @(posedge clk);
        #1;
        arm   = 1'b0;
        abort = 1'b0;

        check({name, "_trig_cycle"}, trig_cyc, exp_trig_cyc);
        if (abort_off == 0) begin
            check({name, "_trig_addr"}, 32'(trig_addr), t % DEPTH);
            check({name, "_done_cycle"}, done_cyc, exp_done_cyc);
            check({name, "_triggered_at_done"}, 32'(triggered), 32'd1);
        end
        check({name, "_write_count"}, n_writes - wr_start, exp_nwr);
        check({name, "_queue_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        for (int i = 0; i < int'(PAT_N); i++) pat[i] = DATA_W'($urandom);
        rst        = 1'b1;
        arm        = 1'b0;
        abort      = 1'b0;
        div        = '0;
        trig_mask  = '0;
        trig_value = '0;
        trig_edge  = '0;
        pre_count  = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_data", 32'(mem_data), 32'd0);
        check("rst_trig_addr", 32'(trig_addr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_triggered", 32'(triggered), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);

        run_capture("counter", 0, 16'h0001, 16'h0001, 16'h0000, 100, 1, 0);
        run_capture("div3", 3, DATA_W'(1 << $urandom_range(0, 15)), DATA_W'($urandom), 16'h0000,
                    $urandom_range(0, 200), 0, 0);
        run_capture("mask0", 0, 16'h0000, DATA_W'($urandom), 16'h0000, 0, 0, 0);
        run_capture("holdoff", 0, 16'h8000, 16'h8000, 16'h0000, 300, 2, 0);
        run_capture("pre_max", 0, 16'h0000, 16'h0000, 16'h0000, 4095, 0, 0);
        for (int r = 0; r < 2; r++) begin
            run_capture("rand", $urandom_range(0, 1), DATA_W'(1 << $urandom_range(0, 15)),
                        DATA_W'($urandom), 16'h0000, $urandom_range(0, 4095), 0, 0);
        end
`ifdef LA_EDGE_TRIG_EN
        run_capture("edge", 0, 16'h0001, 16'h0001, 16'h0001, 0, 3, 0);
`endif
        run_capture("abort_post", 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 50);

        // arm and abort together in IDLE: nothing starts.
        @(posedge clk);
        #1;
        arm   = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        arm   = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        check("armabort_busy", 32'(busy), 32'd0);
        check("armabort_done", 32'(done), 32'd0);
        check("armabort_trig", 32'(triggered), 32'd0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("armabort_busy_later", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
